// File: rtl/layer_sequencer_if.sv
// Host/datapath-facing signal bundle for layer_sequencer: program load, run control,
// layer completion and the registered instruction outputs.
interface layer_sequencer_if #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int ADDR_WIDTH        = 4
);
    logic                         prog_we;
    logic [ADDR_WIDTH-1:0]        prog_addr;
    logic [INSTRUCTION_WIDTH-1:0] prog_data;
    logic [ADDR_WIDTH:0]          prog_len;
    logic                         start;
    logic                         layer_done;
    logic [INSTRUCTION_WIDTH-1:0] instruction_signal;
    logic                         instr_valid;
    logic [ADDR_WIDTH-1:0]        pc;
    logic                         busy;
    logic                         done;

    // Host/datapath side drives the program and handshake inputs.
    modport master (
        output prog_we, prog_addr, prog_data, prog_len, start, layer_done,
        input  instruction_signal, instr_valid, pc, busy, done
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len, start, layer_done,
        output instruction_signal, instr_valid, pc, busy, done
    );
endinterface

// File: rtl/layer_sequencer.sv
// Steps through a host-loaded program of layer instructions, presenting one at a time
// to the layer controller and advancing each time the datapath reports the layer done.
module layer_sequencer #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int PROG_DEPTH        = 16,
    parameter int ADDR_WIDTH        = 4
) (
    input logic              clk,
    input logic              rst,
    layer_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(PROG_DEPTH);

    logic [INSTRUCTION_WIDTH-1:0] r_mem [PROG_DEPTH];

    state_t                       r_state,  w_state_nxt;
    logic [ADDR_WIDTH:0]          r_len,    w_len_nxt;
    logic [ADDR_WIDTH-1:0]        r_pc,     w_pc_nxt;
    logic [INSTRUCTION_WIDTH-1:0] r_instr,  w_instr_nxt;
    logic                         r_valid,  w_valid_nxt;
    logic                         r_busy,   w_busy_nxt;
    logic                         r_done,   w_done_nxt;

    logic [ADDR_WIDTH:0]          w_len_capped;
    logic                         w_pc_is_last;

    // NOTE: the program store has no reset; it must survive rst and is only
    // ever written by the host, so clearing it would also cost a wide reset tree.
    always_ff @(posedge clk) begin
        if (bus.prog_we && (r_state == S_IDLE)) begin
            r_mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign w_len_capped = (bus.prog_len > LP_DEPTH) ? LP_DEPTH : bus.prog_len;
    assign w_pc_is_last = (({1'b0, r_pc} + (ADDR_WIDTH+1)'(1)) == r_len);

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred; blocking '=' is correct in
    // combinational logic, while the registers below use '<=' only.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.prog_len == '0) begin
                        // Empty program completes immediately without ever going busy.
                        w_done_nxt = 1'b1;
                    end else begin
                        w_len_nxt   = w_len_capped;
                        w_pc_nxt    = '0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_instr_nxt = r_mem[r_pc];
                w_valid_nxt = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.layer_done) begin
                    if (w_pc_is_last) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_pc_nxt    = r_pc + ADDR_WIDTH'(1);
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                w_instr_nxt = '0;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_pc_nxt    = '0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.instruction_signal = r_instr;
    assign bus.instr_valid        = r_valid;
    assign bus.pc                 = r_pc;
    assign bus.busy               = r_busy;
    assign bus.done               = r_done;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: basic run, ignored events, zero/over length,
// back-to-back advance and asynchronous reset mid-program.
module tb_layer_sequencer;

    localparam int IW = 32;
    localparam int PD = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [IW-1:0] prog [PD];

    always #5 clk = ~clk;

    layer_sequencer_if #(.INSTRUCTION_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

    layer_sequencer #(
        .INSTRUCTION_WIDTH(IW),
        .PROG_DEPTH       (PD),
        .ADDR_WIDTH       (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [IW-1:0] instr, input logic valid,
                             input logic [AW-1:0] pc, input logic busy, input logic done);
        check({tag, ".instr"}, bus.instruction_signal, instr);
        check({tag, ".valid"}, IW'(bus.instr_valid), IW'(valid));
        check({tag, ".pc"},    IW'(bus.pc),          IW'(pc));
        check({tag, ".busy"},  IW'(bus.busy),        IW'(busy));
        check({tag, ".done"},  IW'(bus.done),        IW'(done));
    endtask

    // Called right after the edge that sampled the final layer_done.
    task automatic run_finish(input string tag, input logic [IW-1:0] last_instr,
                              input logic [AW-1:0] last_pc);
        check_out({tag, ".fin"}, last_instr, 1'b0, last_pc, 1'b1, 1'b0);
        step();
        check_out({tag, ".done"}, '0, 1'b0, '0, 1'b0, 1'b1);
        step();
        check_out({tag, ".clr"}, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
        bus.prog_len   = '0;
        bus.start      = 1'b0;
        bus.layer_done = 1'b0;

        step();
        step();
        check_out("reset", '0, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_out("idle", '0, 1'b0, '0, 1'b0, 1'b0);

        // Program: {0x0, 0x1, 0x0, 0x103, 0x104, ... 0x10f}
        for (int i = 0; i < PD; i++) begin
            prog[i]       = (i == 1) ? 32'h1 : ((i == 0 || i == 2) ? 32'h0 : (32'h100 + IW'(i)));
            bus.prog_we   = 1'b1;
            bus.prog_addr = AW'(i);
            bus.prog_data = prog[i];
            step();
        end
        bus.prog_we = 1'b0;

        // Basic run, layer_done 5 cycles after each instr_valid
        bus.prog_len = 5'd3;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        check_out("basic.e0", '0, 1'b0, '0, 1'b1, 1'b0);
        step();
        check_out("basic.i0", prog[0], 1'b1, 4'd0, 1'b1, 1'b0);
        for (int l = 0; l < 3; l++) begin
            repeat (4) step();
            check_out($sformatf("basic.hold%0d", l), prog[l], 1'b0, AW'(l), 1'b1, 1'b0);
            bus.layer_done = 1'b1;
            step();
            bus.layer_done = 1'b0;
            if (l < 2) begin
                check_out($sformatf("basic.turn%0d", l), prog[l], 1'b0, AW'(l + 1), 1'b1, 1'b0);
                step();
                check_out($sformatf("basic.i%0d", l + 1), prog[l + 1], 1'b1, AW'(l + 1), 1'b1, 1'b0);
            end else begin
                run_finish("basic", prog[2], 4'd2);
            end
        end

        // Ignored events: layer_done in ISSUE, start and prog_we while busy
        bus.prog_len = 5'd3;
        bus.start    = 1'b1;
        step();
        bus.start      = 1'b0;
        bus.layer_done = 1'b1;
        step();
        bus.layer_done = 1'b0;
        check_out("ign.i0", prog[0], 1'b1, 4'd0, 1'b1, 1'b0);
        bus.start     = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd1;
        bus.prog_data = 32'hDEAD_BEEF;
        step();
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        step();
        check_out("ign.stay", prog[0], 1'b0, 4'd0, 1'b1, 1'b0);
        bus.layer_done = 1'b1;
        step();
        bus.layer_done = 1'b0;
        step();
        check_out("ign.i1", prog[1], 1'b1, 4'd1, 1'b1, 1'b0);
        bus.layer_done = 1'b1;
        step();
        bus.layer_done = 1'b0;
        step();
        check_out("ign.i2", prog[2], 1'b1, 4'd2, 1'b1, 1'b0);
        bus.layer_done = 1'b1;
        step();
        bus.layer_done = 1'b0;
        run_finish("ign", prog[2], 4'd2);

        // Zero length
        bus.prog_len = 5'd0;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        check_out("zero.e0", '0, 1'b0, '0, 1'b0, 1'b1);
        step();
        check_out("zero.e1", '0, 1'b0, '0, 1'b0, 1'b0);

        // Over length: 20 requested, 16 issued, layer_done held high
        bus.prog_len   = 5'd20;
        bus.start      = 1'b1;
        bus.layer_done = 1'b1;
        step();
        bus.start = 1'b0;
        check_out("over.e0", '0, 1'b0, '0, 1'b1, 1'b0);
        step();
        check_out("over.i0", prog[0], 1'b1, 4'd0, 1'b1, 1'b0);
        for (int i = 1; i < PD; i++) begin
            step();
            step();
            check_out($sformatf("over.i%0d", i), prog[i], 1'b1, AW'(i), 1'b1, 1'b0);
        end
        step();
        run_finish("over", prog[15], 4'd15);
        bus.layer_done = 1'b0;

        // Back-to-back run of 4: done 8 cycles after first instr_valid
        bus.prog_len   = 5'd4;
        bus.start      = 1'b1;
        bus.layer_done = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check_out("b2b.i0", prog[0], 1'b1, 4'd0, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step();
            check_out($sformatf("b2b.gap%0d", i), prog[i - 1], 1'b0, AW'(i), 1'b1, 1'b0);
            step();
            check_out($sformatf("b2b.i%0d", i), prog[i], 1'b1, AW'(i), 1'b1, 1'b0);
        end
        step();
        run_finish("b2b", prog[3], 4'd3);
        bus.layer_done = 1'b0;

        // Asynchronous reset during WAIT at pc=2, then restart
        bus.prog_len = 5'd4;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.layer_done = 1'b1;
        step();
        bus.layer_done = 1'b0;
        step();
        bus.layer_done = 1'b1;
        step();
        bus.layer_done = 1'b0;
        step();
        check_out("rst.i2", prog[2], 1'b1, 4'd2, 1'b1, 1'b0);
        step();
        check_out("rst.wait", prog[2], 1'b0, 4'd2, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1 check_out("rst.async", '0, 1'b0, '0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check_out("rst.re0", prog[0], 1'b1, 4'd0, 1'b1, 1'b0);
        bus.layer_done = 1'b1;
        step();
        bus.layer_done = 1'b0;
        step();
        check_out("rst.re1", prog[1], 1'b1, 4'd1, 1'b1, 1'b0);
        bus.layer_done = 1'b1;
        step();
        bus.layer_done = 1'b0;
        step();
        bus.layer_done = 1'b1;
        step();
        bus.layer_done = 1'b0;
        step();
        check_out("rst.re3", prog[3], 1'b1, 4'd3, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
